// File: rtl/mux_4to1_pkg.sv
// Shared constants and lane-select encoding for the registered 4-to-1 lane selector.
// No logic here; imported by the interface and the combinational core.
package mux_4to1_pkg;

    localparam int SEL_W   = 2;
    localparam int N_LANES = 4;

    typedef enum logic [SEL_W-1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } lane_sel_e;

endpackage

// File: rtl/mux_4to1_if.sv
// Lane-select bus: capture enable, select and packed lanes in; registered lane and valid out.
// Lane k of 'in' occupies in[k*DATA_W +: DATA_W], so lane 0 sits in the LSBs.
interface mux_4to1_if #(
    parameter int DATA_W = 1
);
    import mux_4to1_pkg::*;

    logic                        en;
    logic [SEL_W-1:0]            sel;
    logic [N_LANES*DATA_W-1:0]   in;
    logic [DATA_W-1:0]           q;
    logic                        q_valid;

    modport master (
        output en, sel, in,
        input  q, q_valid
    );

    modport slave (
        input  en, sel, in,
        output q, q_valid
    );

endinterface

// File: rtl/mux_4to1_core.sv
// Combinational lane picker: returns lane sel_i of the packed bus in_i.
// Zero latency, no state, no backpressure; every select code is a legal lane.
module mux_4to1_core
    import mux_4to1_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic [SEL_W-1:0]          sel_i,
    input  logic [N_LANES*DATA_W-1:0] in_i,
    output logic [DATA_W-1:0]         lane_o
);

    always_comb begin
        lane_o = '0;
        case (lane_sel_e'(sel_i))
            LANE0: lane_o = in_i[0*DATA_W +: DATA_W];
            LANE1: lane_o = in_i[1*DATA_W +: DATA_W];
            LANE2: lane_o = in_i[2*DATA_W +: DATA_W];
            LANE3: lane_o = in_i[3*DATA_W +: DATA_W];
        endcase
    end

endmodule

// File: rtl/mux_4to1.sv
// Registered 4-to-1 lane selector: q takes the selected lane one clock after an enabled edge.
// No backpressure; en low holds q and drops q_valid, rst_n low clears both at once.
module mux_4to1 #(
    parameter int DATA_W = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_4to1_if.slave  bus
);

    logic [DATA_W-1:0] lane_sel;
    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] q_q;
    logic              valid_q;

    mux_4to1_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .sel_i  (bus.sel),
        .in_i   (bus.in),
        .lane_o (lane_sel)
    );

    always_comb begin
        q_d = q_q;
        if (bus.en) begin
            q_d = lane_sel;
        end
    end

    // Reset wins over en: the held lane value is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= bus.en;
        end
    end

    assign bus.q       = q_q;
    assign bus.q_valid = valid_q;

endmodule

// File: tb/tb_mux_4to1.sv
// Directed table-driven bench for mux_4to1 at DATA_W = 1 and DATA_W = 8.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the next edge.
module tb_mux_4to1;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_bad;

    mux_4to1_if #(.DATA_W(1)) nb ();
    mux_4to1_if #(.DATA_W(8)) wb ();

    mux_4to1 #(.DATA_W(1)) u_nar (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (nb)
    );

    mux_4to1 #(.DATA_W(8)) u_wide (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] sel;
        logic [3:0] in;
        logic       exp_q;
        logic       exp_v;
        string      name;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic prev_q;

    initial begin
        n_vec = 0;
        n_bad = 0;

        vt[0]  = '{1'b1, 2'd2, 4'b1000, 1'b0, 1'b1, "l2_1000a"};
        vt[1]  = '{1'b1, 2'd2, 4'b1010, 1'b0, 1'b1, "l2_1010"};
        vt[2]  = '{1'b1, 2'd2, 4'b1000, 1'b0, 1'b1, "l2_1000b"};
        vt[3]  = '{1'b1, 2'd2, 4'b1011, 1'b0, 1'b1, "l2_1011"};
        vt[4]  = '{1'b1, 2'd2, 4'b1111, 1'b1, 1'b1, "l2_1111"};
        vt[5]  = '{1'b1, 2'd2, 4'b0010, 1'b0, 1'b1, "l2_0010"};
        vt[6]  = '{1'b1, 2'd2, 4'b0100, 1'b1, 1'b1, "l2_0100"};
        vt[7]  = '{1'b1, 2'd2, 4'b1110, 1'b1, 1'b1, "l2_1110"};
        vt[8]  = '{1'b1, 2'd2, 4'b0011, 1'b0, 1'b1, "l2_0011"};
        vt[9]  = '{1'b1, 2'd0, 4'b0101, 1'b1, 1'b1, "all_s0"};
        vt[10] = '{1'b1, 2'd1, 4'b0101, 1'b0, 1'b1, "all_s1"};
        vt[11] = '{1'b1, 2'd2, 4'b0101, 1'b1, 1'b1, "all_s2"};
        vt[12] = '{1'b1, 2'd3, 4'b0101, 1'b0, 1'b1, "all_s3"};
        vt[13] = '{1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, "hold_set"};
        vt[14] = '{1'b0, 2'd1, 4'b0001, 1'b1, 1'b0, "hold_1"};
        vt[15] = '{1'b0, 2'd1, 4'b0001, 1'b1, 1'b0, "hold_2"};
        vt[16] = '{1'b0, 2'd1, 4'b0001, 1'b1, 1'b0, "hold_3"};
        vt[17] = '{1'b1, 2'd1, 4'b0001, 1'b0, 1'b1, "hold_reen"};

        // Reset held with an active request: outputs must stay cleared.
        rst_n  = 1'b0;
        nb.en  = 1'b1;
        nb.sel = 2'd2;
        nb.in  = 4'b1111;
        wb.en  = 1'b0;
        wb.sel = 2'd0;
        wb.in  = '0;
        #2;
        chk("rst_q_async", {7'd0, nb.q}, 8'd0);
        chk("rst_v_async", {7'd0, nb.q_valid}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_q_hold", {7'd0, nb.q}, 8'd0);
            chk("rst_v_hold", {7'd0, nb.q_valid}, 8'd0);
            chk("rst_wq_hold", wb.q, 8'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_rel_q", {7'd0, nb.q}, 8'd1);
        chk("rst_rel_v", {7'd0, nb.q_valid}, 8'd1);
        prev_q = 1'b1;

        for (int i = 0; i < 18; i++) begin
            nb.en  = vt[i].en;
            nb.sel = vt[i].sel;
            nb.in  = vt[i].in;
            #2;
            chk({vt[i].name, "_pre"}, {7'd0, nb.q}, {7'd0, prev_q});
            step();
            chk({vt[i].name, "_q"}, {7'd0, nb.q}, {7'd0, vt[i].exp_q});
            chk({vt[i].name, "_v"}, {7'd0, nb.q_valid}, {7'd0, vt[i].exp_v});
            prev_q = vt[i].exp_q;
        end

        // Asynchronous reset between edges while q = 1.
        nb.en  = 1'b1;
        nb.sel = 2'd0;
        nb.in  = 4'b0001;
        step();
        chk("mid_set_q", {7'd0, nb.q}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_q", {7'd0, nb.q}, 8'd0);
        chk("mid_rst_v", {7'd0, nb.q_valid}, 8'd0);
        step();
        chk("mid_rst_q_edge", {7'd0, nb.q}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("mid_rel_q", {7'd0, nb.q}, 8'd1);
        chk("mid_rel_v", {7'd0, nb.q_valid}, 8'd1);

        // Wide lanes: each select code must pick its own byte.
        wb.en  = 1'b1;
        wb.in  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        wb.sel = 2'd3;
        step();
        chk("wide_s3", wb.q, 8'hDD);
        chk("wide_s3_v", {7'd0, wb.q_valid}, 8'd1);
        wb.sel = 2'd0;
        step();
        chk("wide_s0", wb.q, 8'hAA);
        wb.sel = 2'd1;
        step();
        chk("wide_s1", wb.q, 8'hBB);
        wb.sel = 2'd2;
        wb.en  = 1'b1;
        step();
        chk("wide_s2", wb.q, 8'hCC);
        wb.en  = 1'b0;
        wb.sel = 2'd3;
        step();
        chk("wide_hold", wb.q, 8'hCC);
        chk("wide_hold_v", {7'd0, wb.q_valid}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_4to1.md
Name: mux_4to1

Overview:
- Registered 4-to-1 selector. Picks one of four equal-width data lanes packed into a single input bus, using a 2-bit select.
- Presents the chosen lane on a registered output one clock later.
- Used as a generic lane-select stage wherever a datapath must choose among four sources. The 1-bit build is the baseline configuration.

Parameters:
- DATA_W, 1, width in bits of each of the four lanes and of q.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; when high, q updates on the next clock edge.
- sel  input  2  lane select, 0..3.
- in  input  4*DATA_W  packed lanes; lane k occupies in[k*DATA_W +: DATA_W], so lane 0 is the LSBs.
- q  output  DATA_W  registered selected lane.
- q_valid  output  1  high for the cycle after any cycle in which en was high.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset:
  - rst_n low forces q = 0 and q_valid = 0 immediately, independent of clk.
  - Both outputs stay at 0 while rst_n is low.
  - Deassertion takes effect at the first rising clk edge after rst_n goes high.
- Select function, combinational core:
  - sel = 0 -> lane 0; sel = 1 -> lane 1; sel = 2 -> lane 2; sel = 3 -> lane 3.
  - Every 2-bit code is legal, so there is no default or error case.
  - With DATA_W = 1: sel = 2'b10 returns in[2].
- Latency:
  - q reflects the sel/in sampled at a rising clk edge where en = 1. It is visible after that edge, i.e. 1-cycle latency.
  - No combinational path from sel or in to q.
- Hold: en = 0 at an edge leaves q unchanged and drives q_valid = 0.
- q_valid: registered copy of en, cleared by reset.
- sel and in may change every cycle. Only values present at an enabled edge matter; glitches between edges have no effect.
- Unknown/X on sel at an enabled edge is not supported. Designs drive sel to a known value whenever en = 1.
- Reset mid-operation: an asserted rst_n overrides en. q returns to 0 and the held value is lost.
- No internal state other than the q and q_valid registers.

Decomposition:
- Shared package mux_4to1_pkg holds:
  - SEL_W = 2 and N_LANES = 4.
  - An enumerated select type with codes LANE0..LANE3 = 0..3.
- One natural sub-module: mux_4to1_core. Purely combinational; inputs sel and in; output the selected lane (DATA_W).
- The top instantiates the core and adds the en-gated output register and the q_valid register.

Test Plan:
- Reset: hold rst_n = 0 with en = 1, sel = 2, in = 4'b1111 -> q = 0 and q_valid = 0 throughout. Release rst_n; the first enabled edge gives q = 1 and q_valid = 1.
- Lane-2 sweep, DATA_W = 1, en = 1, sel = 2'b10, one value per cycle:
  - in = 1000, 1010, 1000, 1011 -> q = 0.
  - in = 1111 -> q = 1.
  - in = 0010 -> q = 0.
  - in = 0100, 1110 -> q = 1.
  - in = 0011 -> q = 0.
  - Each result appears one cycle after its input.
- All selects: in = 4'b0101 with sel = 0, 1, 2, 3 on consecutive enabled cycles -> q = 1, 0, 1, 0.
- Hold:
  - Set q = 1 via sel = 0, in = 0001.
  - Then drive en = 0, sel = 1, in = 0001 for 3 cycles -> q stays 1 and q_valid = 0.
  - Re-enable -> q = 0.
- Async reset mid-stream: assert rst_n between clock edges while q = 1 -> q drops to 0 before the next edge.
- Wide build, DATA_W = 8: in = {8'hDD, 8'hCC, 8'hBB, 8'hAA} with sel = 3 -> q = 8'hDD; sel = 0 -> q = 8'hAA.
